// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the framebuffer port arbiter.
package vga_fb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_WR_MAX_BURST = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DISP = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

    // Width of a counter that must hold 0..max inclusive.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/vga_fb_arb_stats.sv
// Arbiter statistics: ack and preemption counters, wrapping; clear beats increment.
// One-cycle update latency, no backpressure.
module vga_fb_arb_stats
    import vga_fb_pkg::*;
(
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        stat_clr,
    input  logic        disp_ack_evt,
    input  logic        wr_ack_evt,
    input  logic        preempt_evt,
    output logic [31:0] stat_disp_acks,
    output logic [31:0] stat_wr_acks,
    output logic [15:0] stat_preempts
);

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst || stat_clr) begin
            stat_disp_acks <= '0;
            stat_wr_acks   <= '0;
            stat_preempts  <= '0;
        end else begin
            if (disp_ack_evt) stat_disp_acks <= stat_disp_acks + 32'd1;
            if (wr_ack_evt)   stat_wr_acks   <= stat_wr_acks + 32'd1;
            if (preempt_evt)  stat_preempts  <= stat_preempts + 16'd1;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Display-priority arbiter sharing one Wishbone framebuffer port; grant 1 cycle after cyc,
// writer is stalled (no ack) while not owner and preempted after WR_MAX_BURST acks. Stats: VGA_FB_ARB_STATS_EN.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int WR_MAX_BURST = DEF_WR_MAX_BURST
) (
    input  logic                  pixel_clk,
    input  logic                  pixel_rst,

    input  logic                  disp_cyc,
    input  logic                  disp_stb,
    input  logic                  disp_we,
    input  logic [ADDR_W-1:0]     disp_adr,
    input  logic [DATA_W-1:0]     disp_dat_w,
    input  logic [DATA_W/8-1:0]   disp_sel,
    output logic                  disp_ack,
    output logic [DATA_W-1:0]     disp_dat_r,

    input  logic                  wr_cyc,
    input  logic                  wr_stb,
    input  logic                  wr_we,
    input  logic [ADDR_W-1:0]     wr_adr,
    input  logic [DATA_W-1:0]     wr_dat_w,
    input  logic [DATA_W/8-1:0]   wr_sel,
    output logic                  wr_ack,
    output logic [DATA_W-1:0]     wr_dat_r,

    output logic                  wbm_cyc,
    output logic                  wbm_stb,
    output logic                  wbm_we,
    output logic [ADDR_W-1:0]     wbm_adr,
    output logic [DATA_W-1:0]     wbm_dat_w,
    output logic [DATA_W/8-1:0]   wbm_sel,
    input  logic                  wbm_ack,
    input  logic [DATA_W-1:0]     wbm_dat_r,

    input  logic                  stat_clr,
    output logic [31:0]           stat_disp_acks,
    output logic [31:0]           stat_wr_acks,
    output logic [15:0]           stat_preempts
);

    localparam int                BCNT_W    = cnt_w(WR_MAX_BURST);
    localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(WR_MAX_BURST);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WR_MAX_BURST - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [BCNT_W-1:0] bcnt;
    logic              ack_ok;
    logic              burst_last;
    logic              preempt;

    // An ack arriving while reset is asserted belongs to an aborted beat.
    assign ack_ok     = wbm_ack & ~pixel_rst;
    assign burst_last = (bcnt >= BCNT_LAST);

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state <= ARB_IDLE;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state != ARB_WR)
                bcnt <= '0;
            else if (ack_ok && bcnt != BCNT_MAX)
                bcnt <= bcnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        preempt   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (disp_cyc)
                    state_nxt = ARB_DISP;
                else if (wr_cyc)
                    state_nxt = ARB_WR;
            end
            ARB_DISP: begin
                if (!disp_cyc)
                    state_nxt = wr_cyc ? ARB_WR : ARB_IDLE;
            end
            ARB_WR: begin
                if (!wr_cyc) begin
                    state_nxt = disp_cyc ? ARB_DISP : ARB_IDLE;
                end else if (ack_ok && burst_last && disp_cyc) begin
                    state_nxt = ARB_DISP;
                    preempt   = 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        wbm_cyc   = 1'b0;
        wbm_stb   = 1'b0;
        wbm_we    = 1'b0;
        wbm_adr   = '0;
        wbm_dat_w = '0;
        wbm_sel   = '0;
        disp_ack  = 1'b0;
        wr_ack    = 1'b0;
        case (state)
            ARB_DISP: begin
                wbm_cyc   = disp_cyc;
                wbm_stb   = disp_stb;
                wbm_we    = disp_we;
                wbm_adr   = disp_adr;
                wbm_dat_w = disp_dat_w;
                wbm_sel   = disp_sel;
                disp_ack  = ack_ok;
            end
            ARB_WR: begin
                wbm_cyc   = wr_cyc;
                wbm_stb   = wr_stb;
                wbm_we    = wr_we;
                wbm_adr   = wr_adr;
                wbm_dat_w = wr_dat_w;
                wbm_sel   = wr_sel;
                wr_ack    = ack_ok;
            end
            default: ;
        endcase
    end

    assign disp_dat_r = wbm_dat_r;
    assign wr_dat_r   = wbm_dat_r;

`ifdef VGA_FB_ARB_STATS_EN
    vga_fb_arb_stats u_stats (
        .pixel_clk      (pixel_clk),
        .pixel_rst      (pixel_rst),
        .stat_clr       (stat_clr),
        .disp_ack_evt   (disp_ack),
        .wr_ack_evt     (wr_ack),
        .preempt_evt    (preempt),
        .stat_disp_acks (stat_disp_acks),
        .stat_wr_acks   (stat_wr_acks),
        .stat_preempts  (stat_preempts)
    );
`else
    logic unused_stat;
    assign unused_stat    = stat_clr ^ preempt;
    assign stat_disp_acks = '0;
    assign stat_wr_acks   = '0;
    assign stat_preempts  = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench: display/writer requesters against a one-cycle-ack memory model.
module tb_vga_fb_arbiter;

`ifdef VGA_FB_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic        disp_cyc, disp_stb, disp_we;
    logic [31:0] disp_adr, disp_dat_w, disp_dat_r;
    logic [3:0]  disp_sel;
    logic        disp_ack;
    logic        wr_cyc, wr_stb, wr_we;
    logic [31:0] wr_adr, wr_dat_w, wr_dat_r;
    logic [3:0]  wr_sel;
    logic        wr_ack;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [31:0] wbm_adr, wbm_dat_w;
    logic [3:0]  wbm_sel;
    logic        wbm_ack;
    logic [31:0] wbm_dat_r;
    logic        stat_clr;
    logic [31:0] stat_disp_acks, stat_wr_acks;
    logic [15:0] stat_preempts;

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          disp_drop_cyc = 0;
    int          first_wr_grant = -1;
    bit          log_own[$];
    logic [31:0] log_adr[$];

    vga_fb_arbiter #(.ADDR_W(32), .DATA_W(32), .WR_MAX_BURST(4)) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .disp_cyc(disp_cyc), .disp_stb(disp_stb), .disp_we(disp_we),
        .disp_adr(disp_adr), .disp_dat_w(disp_dat_w), .disp_sel(disp_sel),
        .disp_ack(disp_ack), .disp_dat_r(disp_dat_r),
        .wr_cyc(wr_cyc), .wr_stb(wr_stb), .wr_we(wr_we),
        .wr_adr(wr_adr), .wr_dat_w(wr_dat_w), .wr_sel(wr_sel),
        .wr_ack(wr_ack), .wr_dat_r(wr_dat_r),
        .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we),
        .wbm_adr(wbm_adr), .wbm_dat_w(wbm_dat_w), .wbm_sel(wbm_sel),
        .wbm_ack(wbm_ack), .wbm_dat_r(wbm_dat_r),
        .stat_clr(stat_clr), .stat_disp_acks(stat_disp_acks),
        .stat_wr_acks(stat_wr_acks), .stat_preempts(stat_preempts)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) cyc_n <= cyc_n + 1;

    // Memory: acks one cycle after a fresh strobe, read data derived from address.
    logic        mem_ack;
    logic [31:0] mem_dat;
    always @(posedge pixel_clk) begin
        if (pixel_rst) begin
            mem_ack <= 1'b0;
            mem_dat <= '0;
        end else begin
            mem_ack <= wbm_cyc & wbm_stb & ~mem_ack;
            mem_dat <= wbm_adr ^ 32'hA5A5_0000;
        end
    end
    assign wbm_ack   = mem_ack;
    assign wbm_dat_r = mem_dat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge pixel_clk) begin
        if (disp_ack || wr_ack) begin
            check("one_ack", 32'(disp_ack & wr_ack), 32'd0);
            check("ack_we", 32'(wbm_we), 32'(wr_ack));
            if (disp_ack) begin
                check("disp_dat_r", disp_dat_r, wbm_adr ^ 32'hA5A5_0000);
                log_own.push_back(1'b1);
            end else begin
                check("wr_dat_w", wbm_dat_w, ~wbm_adr);
                log_own.push_back(1'b0);
            end
            log_adr.push_back(wbm_adr);
        end
        if (wbm_cyc && wbm_we && first_wr_grant < 0)
            first_wr_grant = cyc_n;
    end

    task automatic wait_ack(input bit is_disp, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge pixel_clk);
            if (pixel_rst) return;
            if (is_disp ? disp_ack : wr_ack) begin
                ok = 1'b1;
                return;
            end
        end
        check(is_disp ? "disp_ack_wait" : "wr_ack_wait", 32'(ok), 32'd1);
    endtask

    task automatic disp_run(input int n, input logic [31:0] base);
        bit ok;
        disp_cyc = 1'b1; disp_stb = 1'b1; disp_we = 1'b0; disp_sel = 4'hF;
        for (int i = 0; i < n; i++) begin
            disp_adr = base + 32'(4 * i);
            wait_ack(1'b1, ok);
            if (!ok) break;
            @(posedge pixel_clk); #1;
        end
        disp_cyc = 1'b0; disp_stb = 1'b0;
        disp_drop_cyc = cyc_n;
    endtask

    task automatic wr_run(input int n, input logic [31:0] base);
        bit ok;
        wr_cyc = 1'b1; wr_stb = 1'b1; wr_we = 1'b1; wr_sel = 4'hF;
        for (int i = 0; i < n; i++) begin
            wr_adr   = base + 32'(4 * i);
            wr_dat_w = ~wr_adr;
            wait_ack(1'b0, ok);
            if (!ok) break;
            @(posedge pixel_clk); #1;
        end
        wr_cyc = 1'b0; wr_stb = 1'b0; wr_we = 1'b0;
    endtask

    task automatic clear_stats();
        @(posedge pixel_clk); #1 stat_clr = 1'b1;
        @(posedge pixel_clk); #1 stat_clr = 1'b0;
        log_own.delete();
        log_adr.delete();
    endtask

    function automatic int n_disp_logged();
        int c = 0;
        foreach (log_own[i]) if (log_own[i]) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        pixel_rst = 1'b1; stat_clr = 1'b0;
        disp_cyc = 0; disp_stb = 0; disp_we = 0; disp_adr = 0; disp_dat_w = 0; disp_sel = 0;
        wr_cyc = 0; wr_stb = 0; wr_we = 0; wr_adr = 0; wr_dat_w = 0; wr_sel = 0;
        repeat (3) @(posedge pixel_clk);
        #1 pixel_rst = 1'b0;
        @(negedge pixel_clk);
        check("rst_wbm_cyc", 32'(wbm_cyc), 32'd0);
        check("rst_wbm_stb", 32'(wbm_stb), 32'd0);
        check("rst_disp_ack", 32'(disp_ack), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_stat_disp", stat_disp_acks, 32'd0);
        check("rst_stat_pre", 32'(stat_preempts), 32'd0);

        // Display only: 8 reads, 1-cycle grant latency.
        @(posedge pixel_clk); #1;
        disp_cyc = 1'b1; disp_stb = 1'b1; disp_adr = 32'h100; disp_sel = 4'hF;
        @(negedge pixel_clk);
        check("t1_lat_idle", 32'(wbm_cyc), 32'd0);
        @(negedge pixel_clk);
        check("t1_lat_grant", 32'(wbm_cyc), 32'd1);
        check("t1_lat_adr", wbm_adr, 32'h100);
        disp_run(8, 32'h100);
        @(negedge pixel_clk);
        check("t1_n_acks", 32'(log_own.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_adr.size(); i++)
            check("t1_adr", log_adr[i], 32'h100 + 32'(4 * i));
        check("t1_n_disp", 32'(n_disp_logged()), 32'd8);
        check("t1_stat_disp", stat_disp_acks, STATS_ON ? 32'd8 : 32'd0);

        // Both requesters rise together from IDLE: display first, writer right after.
        log_own.delete(); log_adr.delete();
        first_wr_grant = -1;
        @(posedge pixel_clk); #1;
        fork
            disp_run(3, 32'h200);
            wr_run(2, 32'h300);
        join
        @(negedge pixel_clk);
        check("t2_n_acks", 32'(log_own.size()), 32'd5);
        if (log_own.size() == 5) begin
            check("t2_first_disp", 32'(log_own[0]), 32'd1);
            check("t2_wr_after", 32'(log_own[3]), 32'd0);
            check("t2_wr_adr", log_adr[3], 32'h300);
        end
        check("t2_wr_grant_cyc", 32'(first_wr_grant), 32'(disp_drop_cyc + 1));

        // Preemption after WR_MAX_BURST=4 writer acks with display waiting.
        clear_stats();
        @(negedge pixel_clk);
        check("t3_clr_wr", stat_wr_acks, 32'd0);
        @(posedge pixel_clk); #1;
        fork
            wr_run(10, 32'h400);
            begin
                for (int t = 0; t < 100 && log_own.size() < 2; t++) @(negedge pixel_clk);
                @(posedge pixel_clk); #1;
                disp_run(3, 32'h500);
            end
        join
        @(negedge pixel_clk);
        check("t3_n_acks", 32'(log_own.size()), 32'd13);
        if (log_own.size() == 13) begin
            check("t3_wr4_own", 32'(log_own[3]), 32'd0);
            check("t3_wr4_adr", log_adr[3], 32'h40C);
            check("t3_disp_own", 32'(log_own[4]), 32'd1);
            check("t3_disp_adr", log_adr[4], 32'h500);
            check("t3_disp_end", 32'(log_own[6]), 32'd1);
            check("t3_wr5_own", 32'(log_own[7]), 32'd0);
            check("t3_wr5_adr", log_adr[7], 32'h410);
            check("t3_last_adr", log_adr[12], 32'h424);
        end
        check("t3_stat_wr", stat_wr_acks, STATS_ON ? 32'd10 : 32'd0);
        check("t3_stat_disp", stat_disp_acks, STATS_ON ? 32'd3 : 32'd0);
        check("t3_stat_pre", 32'(stat_preempts), STATS_ON ? 32'd1 : 32'd0);

        // Writer alone, 40 beats: never preempted.
        clear_stats();
        @(posedge pixel_clk); #1;
        wr_run(40, 32'h600);
        @(negedge pixel_clk);
        check("t4_n_acks", 32'(log_own.size()), 32'd40);
        check("t4_n_disp", 32'(n_disp_logged()), 32'd0);
        if (log_adr.size() == 40) check("t4_last_adr", log_adr[39], 32'h69C);
        check("t4_stat_wr", stat_wr_acks, STATS_ON ? 32'd40 : 32'd0);
        check("t4_stat_pre", 32'(stat_preempts), 32'd0);

        // Reset mid-burst while memory ack is high.
        log_own.delete(); log_adr.delete();
        @(posedge pixel_clk); #1;
        fork
            wr_run(10, 32'h700);
            begin
                for (int t = 0; t < 100 && !(log_own.size() >= 2 && wr_ack); t++)
                    @(negedge pixel_clk);
                check("t5_ack_before_rst", 32'(wr_ack), 32'd1);
                pixel_rst = 1'b1;
                @(negedge pixel_clk);
                check("t5_wbm_cyc", 32'(wbm_cyc), 32'd0);
                check("t5_wbm_stb", 32'(wbm_stb), 32'd0);
                check("t5_wr_ack", 32'(wr_ack), 32'd0);
                check("t5_stat_wr", stat_wr_acks, 32'd0);
                check("t5_stat_disp", stat_disp_acks, 32'd0);
                @(posedge pixel_clk); #1 pixel_rst = 1'b0;
            end
        join

        // Recovery after reset.
        log_own.delete(); log_adr.delete();
        @(posedge pixel_clk); #1;
        disp_run(2, 32'h800);
        @(negedge pixel_clk);
        check("t6_n_acks", 32'(log_own.size()), 32'd2);
        check("t6_stat_disp", stat_disp_acks, STATS_ON ? 32'd2 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
